spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) with an Avalon-MM slave register interface.
- Complements the team's SPI master. Lets the FPGA act as a peripheral on an external SPI bus and exchange DATA_WIDTH-bit words with a host CPU.
- SPI inputs are asynchronous to clk. They are synchronised and edge-detected, so clk must run at least 4x the sclk frequency.

Parameters:
- DATA_WIDTH, 32: SPI word length in bits, range 8..32.
- SYNC_STAGES, 2: synchroniser flops on sclk, ss_n and mosi; minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- sclk  in  1  SPI clock from master
- ss_n  in  1  slave select, active-low
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- miso_oe  out  1  miso output enable; 1 only while selected
- avs_address  in  2  register select
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, registered
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- irq  out  1  interrupt, level-high

Interface (already decided): reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: miso=0, miso_oe=0, avs_readdata=0, irq=0, FSM=IDLE, tx_hold=0, rx_data=0, rx_valid=0, tx_empty=1, overrun=0, irq_en=0.
- Register map (word address):
  - 0 TX_DATA: write loads tx_hold and clears tx_empty; read returns tx_hold.
  - 1 RX_DATA: read returns rx_data, zero-extended, and clears rx_valid.
  - 2 STATUS (read): bit0 rx_valid, bit1 tx_empty, bit2 overrun, bit3 busy (FSM=ACTIVE), other bits 0.
  - 2 STATUS (write): writing 1 to bit2 clears overrun; other bits ignored.
  - 3 CONTROL: bit0 irq_en, read/write.
- Avalon timing: zero wait states. avs_readdata updates the cycle after avs_read and holds otherwise. Read has priority over write when both are asserted.
- irq = irq_en & (rx_valid | overrun), registered.
- Synchronisation: SYNC_STAGES-flop chain per input, plus one history flop each for sclk and ss_n. Edge pulses are one clk wide.
- FSM IDLE:
  - miso_oe=0, miso=0.
  - On ss_n falling edge: load tx_shift from tx_hold, set tx_empty=1, bit_cnt=0, miso=tx_hold[DATA_WIDTH-1], miso_oe=1, go to ACTIVE.
- FSM ACTIVE, sclk rising edge:
  - rx_shift <= {rx_shift, mosi_sync}; bit_cnt++.
- FSM ACTIVE, sclk falling edge:
  - tx_shift shifts left by 1; miso takes the new MSB.
- Word complete (rising edge with bit_cnt = DATA_WIDTH-1):
  - rx_data <= assembled word; rx_valid=1; bit_cnt=0.
  - If rx_valid was already 1: overrun=1, and rx_data is still overwritten with the new word.
  - tx_shift reloads from tx_hold and tx_empty is set to 1. If tx_empty was already 1, the stale tx_hold is re-sent.
  - Back-to-back words therefore need no ss_n toggle.
- ss_n rising edge, any time: return to IDLE. A partial word is discarded (rx_data and rx_valid unchanged), bit_cnt=0, miso_oe=0 on the next cycle.
- Simultaneous events:
  - RX_DATA read in the same cycle as word completion: completion wins, rx_valid stays 1, readdata returns the old rx_data.
  - TX_DATA write in the same cycle as a reload: the reload takes the old tx_hold, the new value lands in tx_hold, and tx_empty ends at 0.
  - Overrun-clear write in the same cycle as a new overrun: overrun stays 1.
- sclk edges while ss_n is high are ignored.
- Asserting reset mid-transfer returns all state to reset values immediately.

Decomposition:
- Package spi_pkg holds:
  - register address constants: ADDR_TX, ADDR_RX, ADDR_STATUS, ADDR_CTRL;
  - STATUS bit indices;
  - FSM state enum {IDLE, ACTIVE}.
- One natural sub-module, spi_sync_edge: parameterised synchroniser plus rise/fall pulse generator, instantiated for sclk, ss_n and mosi (mosi uses the level output only).

Test Plan:
- Reset, then read addresses 0..3 -> 0x0, 0x0, 0x2 (tx_empty), 0x0; miso_oe=0.
- Write TX=0xA5A5_F00D; master sends 32 bits of 0x1234_5678 with sclk=clk/8 -> miso stream is 0xA5A5F00D MSB first; STATUS=0x3; RX read returns 0x12345678; STATUS then 0x2.
- Two back-to-back words 0x11111111, 0x22222222 without an RX read in between -> STATUS bit2=1, RX=0x22222222. Write STATUS 0x4 -> overrun clears.
- ss_n deasserted after 13 bits -> rx_valid stays 0, busy=0 within 4 clk. A following full word 0xDEADBEEF is received intact.
- CONTROL=1, complete one word -> irq rises 1 cycle after rx_valid. RX read -> irq drops the next cycle. CONTROL=0 -> irq stays 0.
- Read of RX in the same cycle as word completion -> readdata is the old word, rx_valid remains 1.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, status bit positions and FSM states for spi_slave
package spi_pkg;

    localparam logic [1:0] ADDR_TX     = 2'd0;
    localparam logic [1:0] ADDR_RX     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_BUSY     = 3;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with one-clk rise/fall pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder with an Avalon-MM register interface
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq
);

    localparam int             CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  BIT_LAST = CW'(DATA_WIDTH - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_s, mosi_unused_rise, mosi_unused_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .async_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .async_i(ss_n),
        .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .async_i(mosi),
        .level_o(mosi_s), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall));

    logic unused_levels;
    assign unused_levels = sclk_lvl ^ ss_lvl;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  rx_valid_q, rx_valid_d, tx_empty_q, tx_empty_d;
    logic                  overrun_q, overrun_d, irq_en_q, irq_en_d, irq_q;
    logic                  miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic [31:0]           readdata_q, readdata_d, status;
    logic                  wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tx_hold_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_valid_q <= rx_valid_d;
            tx_empty_q <= tx_empty_d;
            overrun_q  <= overrun_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_en_q & (rx_valid_q | overrun_q);
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_hold_d  = tx_hold_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        rx_valid_d = rx_valid_q;
        tx_empty_d = tx_empty_q;
        overrun_d  = overrun_q;
        irq_en_d   = irq_en_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        readdata_d = readdata_q;
        wr         = avs_write & ~avs_read;

        status              = '0;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_TX_EMPTY] = tx_empty_q;
        status[ST_OVERRUN]  = overrun_q;
        status[ST_BUSY]     = (state_q == ACTIVE);

        // Register side first so that SPI events below win any collision.
        if (avs_read) begin
            case (avs_address)
                ADDR_TX:     readdata_d = 32'(tx_hold_q);
                ADDR_RX:     readdata_d = 32'(rx_data_q);
                ADDR_STATUS: readdata_d = status;
                default:     readdata_d = {31'd0, irq_en_q};
            endcase
            if (avs_address == ADDR_RX) rx_valid_d = 1'b0;
        end
        if (wr && avs_address == ADDR_STATUS && avs_writedata[ST_OVERRUN]) overrun_d = 1'b0;
        if (wr && avs_address == ADDR_CTRL) irq_en_d = avs_writedata[0];

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                bit_cnt_d = '0;
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_hold_q;
                    tx_empty_d = 1'b1;
                    miso_d     = tx_hold_q[DATA_WIDTH-1];
                    miso_oe_d  = 1'b1;
                end
            end
            default: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q) overrun_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_shift_d = tx_hold_q;
                        tx_empty_d = 1'b1;
                        miso_d     = tx_hold_q[DATA_WIDTH-1];
                    end
                // A falling edge with bit_cnt=0 follows a reload; the new MSB must stay put.
                end else if (sclk_fall && bit_cnt_q != '0) begin
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[DATA_WIDTH-2];
                end
            end
        endcase

        if (wr && avs_address == ADDR_TX) begin
            tx_hold_d  = avs_writedata[DATA_WIDTH-1:0];
            tx_empty_d = 1'b0;
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = miso_oe_q;
    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe, irq;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_readdata, avs_writedata = '0;

    int tests = 0;
    int fails = 0;

    spi_slave #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .avs_address(avs_address),
        .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .irq(irq));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    // Sends the top nbits of tx MSB first with sclk = clk/8; returns miso sampled before each rise.
    task automatic spi_bits(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int i = 31; i > 31 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(4);
            rx[i] = miso;
            sclk  = 1'b1;
            wait_clk(4);
            sclk  = 1'b0;
        end
    endtask

    task automatic select();
        ss_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic deselect();
        ss_n = 1'b1;
        wait_clk(6);
    endtask

    logic [31:0] d, m, m2;

    initial begin
        // Reset
        wait_clk(3);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        wait_clk(2);
        avs_rd(2'd0, d); check("rst_tx", d, 32'h0);
        avs_rd(2'd1, d); check("rst_rx", d, 32'h0);
        avs_rd(2'd2, d); check("rst_status", d, 32'h2);
        avs_rd(2'd3, d); check("rst_ctrl", d, 32'h0);

        // Single word exchange
        avs_wr(2'd0, 32'hA5A5_F00D);
        avs_rd(2'd2, d); check("status_tx_loaded", d, 32'h0);
        select();
        check("miso_oe_active", {31'd0, miso_oe}, 32'd1);
        spi_bits(32'h1234_5678, 32, m);
        check("miso_word1", m, 32'hA5A5_F00D);
        deselect();
        check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
        avs_rd(2'd2, d); check("status_after_word", d, 32'h3);
        avs_rd(2'd1, d); check("rx_word1", d, 32'h1234_5678);
        avs_rd(2'd2, d); check("status_after_rd", d, 32'h2);

        // Back-to-back words, stale tx_hold re-sent, overrun
        select();
        spi_bits(32'h1111_1111, 32, m);
        spi_bits(32'h2222_2222, 32, m2);
        deselect();
        check("miso_b2b_1", m, 32'hA5A5_F00D);
        check("miso_b2b_2", m2, 32'hA5A5_F00D);
        avs_rd(2'd2, d); check("status_overrun", d, 32'h7);
        avs_rd(2'd1, d); check("rx_b2b", d, 32'h2222_2222);
        avs_wr(2'd2, 32'h4);
        avs_rd(2'd2, d); check("status_ovr_clr", d, 32'h2);

        // Aborted partial word, then a full word
        select();
        spi_bits(32'hFFFF_FFFF, 13, m);
        ss_n = 1'b1;
        wait_clk(4);
        avs_rd(2'd2, d); check("status_partial", d, 32'h2);
        select();
        spi_bits(32'hDEAD_BEEF, 32, m);
        deselect();
        avs_rd(2'd1, d); check("rx_after_partial", d, 32'hDEAD_BEEF);

        // Interrupt
        avs_wr(2'd3, 32'h1);
        avs_rd(2'd3, d); check("ctrl_rd", d, 32'h1);
        check("irq_idle", {31'd0, irq}, 32'd0);
        select();
        spi_bits(32'hCAFE_0001, 32, m);
        deselect();
        check("irq_set", {31'd0, irq}, 32'd1);
        avs_rd(2'd1, d); check("rx_irq_word", d, 32'hCAFE_0001);
        check("irq_still_set", {31'd0, irq}, 32'd1);
        wait_clk(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        avs_wr(2'd3, 32'h0);
        select();
        spi_bits(32'h0F0F_0F0F, 32, m);
        deselect();
        wait_clk(2);
        check("irq_masked", {31'd0, irq}, 32'd0);
        avs_rd(2'd1, d); check("rx_masked_word", d, 32'h0F0F_0F0F);

        // RX read coinciding with word completion
        select();
        spi_bits(32'h1357_9BDF, 31, m);
        mosi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(2);
        avs_rd(2'd1, d); check("rx_collide_old", d, 32'h0F0F_0F0F);
        wait_clk(2);
        sclk = 1'b0;
        deselect();
        avs_rd(2'd2, d); check("status_collide", d, 32'h3);
        avs_rd(2'd1, d); check("rx_collide_new", d, 32'h1357_9BDF);

        // Reset mid-transfer
        avs_wr(2'd0, 32'h8000_0001);
        avs_wr(2'd3, 32'h1);
        select();
        spi_bits(32'hFFFF_FFFF, 10, m);
        reset_n = 1'b0;
        #1;
        check("rst_mid_miso_oe", {31'd0, miso_oe}, 32'd0);
        ss_n = 1'b1;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
        avs_rd(2'd0, d); check("rst_mid_tx", d, 32'h0);
        avs_rd(2'd2, d); check("rst_mid_status", d, 32'h2);
        avs_rd(2'd3, d); check("rst_mid_ctrl", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
